// File: rtl/key_entry_buffer.sv
// key_entry_buffer: collects keypad digits into an HH:MM shift buffer,
// validates on ALARM/TIME and strobes the load, error or timeout outputs.
module key_entry_buffer #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] key_buffer_ms_hr,
  output logic [3:0] key_buffer_ls_hr,
  output logic [3:0] key_buffer_ms_min,
  output logic [3:0] key_buffer_ls_min,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_keyboard,
  output logic       entry_error,
  output logic       entry_timeout
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ENTRY = 1'b1;
  localparam logic [7:0] TMAX = 8'(TIMEOUT_SEC - 1);
  logic [0:0] r_state;
  logic [2:0] r_count;
  logic [7:0] r_timer;
  logic [3:0] r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  logic       r_load_a, r_load_c, r_show, r_error, r_timeout;
  logic       w_digit, w_cmd, w_clear, w_valid;
  assign w_digit = key_valid && key <= 4'd9;
  assign w_cmd   = key_valid && (key == 4'hA || key == 4'hB);
  assign w_clear = key_valid && key == 4'hC;
  assign w_valid = r_count == 3'd4 && r_ms_hr <= 4'd2 &&
                   (r_ms_hr == 4'd2 ? r_ls_hr <= 4'd3 : r_ls_hr <= 4'd9) &&
                   r_ms_min <= 4'd5 && r_ls_min <= 4'd9;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_timer   <= '0;
      r_ms_hr   <= '0;
      r_ls_hr   <= '0;
      r_ms_min  <= '0;
      r_ls_min  <= '0;
      r_load_a  <= 1'b0;
      r_load_c  <= 1'b0;
      r_show    <= 1'b0;
      r_error   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_load_a  <= 1'b0;
      r_load_c  <= 1'b0;
      r_error   <= 1'b0;
      r_timeout <= 1'b0;
      if (r_state == IDLE) begin
        if (w_digit) begin
          {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= {12'h000, key};
          r_count <= 3'd1;
          r_timer <= '0;
          r_show  <= 1'b1;
          r_state <= ENTRY;
        end
      end else if (w_digit) begin
        {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= {r_ls_hr, r_ms_min, r_ls_min, key};
        r_count <= r_count == 3'd4 ? 3'd4 : r_count + 3'd1;
        r_timer <= '0;
      end else if (w_cmd || w_clear) begin
        // A valid commit leaves the buffer intact so the consumer samples stable data.
        if (!(w_cmd && w_valid)) {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= '0;
        r_load_a <= w_cmd && w_valid && key == 4'hA;
        r_load_c <= w_cmd && w_valid && key == 4'hB;
        r_error  <= w_cmd && !w_valid;
        r_timer  <= '0;
        r_show   <= 1'b0;
        r_state  <= IDLE;
      end else if (one_second) begin
        if (r_timer == TMAX) begin
          {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= '0;
          r_timeout <= 1'b1;
          r_timer   <= '0;
          r_show    <= 1'b0;
          r_state   <= IDLE;
        end else begin
          r_timer <= r_timer + 8'd1;
        end
      end
    end
  end
  assign key_buffer_ms_hr  = r_ms_hr;
  assign key_buffer_ls_hr  = r_ls_hr;
  assign key_buffer_ms_min = r_ms_min;
  assign key_buffer_ls_min = r_ls_min;
  assign load_new_a        = r_load_a;
  assign load_new_c        = r_load_c;
  assign show_keyboard     = r_show;
  assign entry_error       = r_error;
  assign entry_timeout     = r_timeout;
endmodule

// File: tb/tb_key_entry_buffer.sv
// tb_key_entry_buffer: directed keypad sequences; expected strobes go to a
// scoreboard queue that a negedge monitor drains whenever a strobe appears.
module tb_key_entry_buffer;
  logic clock = 1'b0, reset = 1'b1, one_second = 1'b0, key_valid = 1'b0;
  logic [3:0] key = '0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic load_a, load_c, show, err, tmo;
  int checks = 0, failures = 0;
  logic [19:0] q[$];
  localparam logic [3:0] S_A = 4'b1000, S_C = 4'b0100, S_E = 4'b0010, S_T = 4'b0001;

  key_entry_buffer #(.TIMEOUT_SEC(10)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .key_valid(key_valid), .key(key),
    .key_buffer_ms_hr(ms_hr), .key_buffer_ls_hr(ls_hr), .key_buffer_ms_min(ms_min),
    .key_buffer_ls_min(ls_min), .load_new_a(load_a), .load_new_c(load_c),
    .show_keyboard(show), .entry_error(err), .entry_timeout(tmo));

  always #5 clock = ~clock;

  wire [15:0] buf_w = {ms_hr, ls_hr, ms_min, ls_min};
  wire [3:0]  strb  = {load_a, load_c, err, tmo};

  always @(negedge clock) begin
    if (!reset && strb != 4'b0000) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected got strobes=%b buf=%h want none", strb, buf_w);
      end else begin
        logic [19:0] e;
        e = q.pop_front();
        if ({strb, buf_w} !== e) begin
          failures++;
          $display("FAIL strobe got strobes=%b buf=%h want strobes=%b buf=%h",
                   strb, buf_w, e[19:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic kv, input logic [3:0] k, input logic tick);
    @(posedge clock); #1;
    key_valid = kv; key = k; one_second = tick;
    @(posedge clock); #1;
    key_valid = 1'b0; one_second = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    cyc(1'b1, k, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b1);
  endtask

  task automatic settle;
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    settle();
    chk("reset_buf", buf_w, 16'h0000);
    chk("reset_flags", {11'd0, show, strb}, 16'h0000);
    press(4'd1); press(4'd2); press(4'd3); press(4'd0);
    settle();
    chk("t1_show", {15'd0, show}, 16'h0001);
    chk("t1_buf", buf_w, 16'h1230);
    q.push_back({S_A, 16'h1230});
    press(4'hA);
    settle();
    chk("t1_show_off", {15'd0, show}, 16'h0000);
    press(4'd0); press(4'd7); press(4'd4); press(4'd5);
    q.push_back({S_C, 16'h0745});
    press(4'hB);
    repeat (3) settle();
    chk("t2_buf_hold", buf_w, 16'h0745);
    press(4'd2); press(4'd5); press(4'd0); press(4'd0);
    q.push_back({S_E, 16'h0000});
    press(4'hA);
    settle();
    chk("t3_buf_clr", buf_w, 16'h0000);
    press(4'd1); press(4'd2);
    q.push_back({S_E, 16'h0000});
    press(4'hA);
    settle();
    chk("t3_short_show", {15'd0, show}, 16'h0000);
    press(4'd9); press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'd9);
    settle();
    chk("t4_buf", buf_w, 16'h2359);
    q.push_back({S_C, 16'h2359});
    press(4'hB);
    press(4'd1); press(4'd9); press(4'd5); press(4'd9);
    q.push_back({S_A, 16'h1959});
    press(4'hA);
    press(4'd4);
    ticks(9);
    settle();
    chk("t5_before_to", {15'd0, show}, 16'h0001);
    q.push_back({S_T, 16'h0000});
    ticks(1);
    settle();
    chk("t5_to_show", {15'd0, show}, 16'h0000);
    chk("t5_to_buf", buf_w, 16'h0000);
    press(4'd4);
    ticks(9);
    cyc(1'b1, 4'd5, 1'b1);
    settle();
    chk("t5_suppress_show", {15'd0, show}, 16'h0001);
    chk("t5_suppress_buf", buf_w, 16'h0045);
    ticks(9);
    q.push_back({S_T, 16'h0000});
    cyc(1'b1, 4'hD, 1'b1);
    settle();
    chk("t5_ignored_tick", {15'd0, show}, 16'h0000);
    press(4'hA);
    settle();
    chk("t6_idle_alarm", {11'd0, show, strb}, 16'h0000);
    press(4'd1);
    press(4'hC);
    settle();
    chk("t6_clear", {buf_w[14:0], show}, 16'h0000);
    press(4'd1); press(4'd2);
    settle();
    chk("t6_mid_entry", {15'd0, show}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_reset", {buf_w[11:0], show, load_a | load_c, err, tmo}, 16'h0000);
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) settle();
    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
